// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the frame FSM encoding, parity-mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Narrower words are zero-extended by the caller; the extra zeros leave the XOR unchanged.
  function automatic logic calc_parity(input logic [8:0] data, input int unsigned mode);
    logic w_xor;
    w_xor = ^data;
    if (mode == PAR_ODD) begin
      return ~w_xor;
    end else if (mode == PAR_EVEN) begin
      return w_xor;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_tx_param.sv
// Parametrised UART serializer running at one serial bit per s_clk cycle.
// Accepts words over valid/ready and chains frames back-to-back without idle gaps.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic                 s_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int unsigned         CntW     = $clog2(DATA_BITS);
  localparam logic [CntW-1:0]     LastBit  = CntW'(DATA_BITS - 1);
  localparam logic                LastStop = (STOP_BITS == 2);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
  endgenerate

  tx_state_e            r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic [CntW-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [CntW-1:0]      w_data_idx;
  logic                 w_last_stop;
  logic                 w_accept;

  assign w_last_stop = (r_state == STOP) && (r_stop_cnt == LastStop);
  assign tx_ready    = (r_state == IDLE) || w_last_stop;
  assign w_accept    = tx_valid && tx_ready;
  assign tx          = r_tx;

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    if (w_accept) begin
      w_shift_nxt = tx_data;
      w_par_nxt   = calc_parity(9'(tx_data), PARITY);
    end
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = START;
      end
      START: begin
        w_state_nxt   = DATA;
        w_bit_cnt_nxt = '0;
      end
      DATA: begin
        if (r_bit_cnt == LastBit) begin
          w_state_nxt    = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          w_stop_cnt_nxt = 1'b0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      uart_pkg::PARITY: begin
        w_state_nxt    = STOP;
        w_stop_cnt_nxt = 1'b0;
      end
      STOP: begin
        if (r_stop_cnt == LastStop) begin
          w_state_nxt = w_accept ? START : IDLE;
        end else begin
          w_stop_cnt_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // tx is registered, so its next value is decoded from the next state and counters.
  always_comb begin
    w_data_idx = (MSB_FIRST != 0) ? (LastBit - w_bit_cnt_nxt) : w_bit_cnt_nxt;
    tx_busy    = (r_state != IDLE);
    tx_done    = w_last_stop;
    unique case (w_state_nxt)
      START:            w_tx_nxt = 1'b0;
      DATA:             w_tx_nxt = w_shift_nxt[w_data_idx];
      uart_pkg::PARITY: w_tx_nxt = w_par_nxt;
      default:          w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations driven with directed and random words,
// each frame compared bit by bit against a frame model built from plain arithmetic.
module tb_uart_tx_param;

  logic       s_clk;
  logic       rst;
  logic       vld   [4];
  logic [8:0] dat   [4];
  logic       rdy_w [4];
  logic       busy_w[4];
  logic       done_w[4];
  logic       tx_w  [4];

  // 0: 8N1, 1: 8E1, 2: 7O2, 3: 8N1 MSB-first
  int db_a  [4] = '{8, 8, 7, 8};
  int par_a [4] = '{0, 2, 1, 0};
  int sb_a  [4] = '{1, 1, 2, 1};
  int msb_a [4] = '{0, 0, 0, 1};

  int checks = 0;
  int errors = 0;

  bit         exp_q  [$];
  bit         last_q [$];
  logic [8:0] words_q[$];

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)) u_8n1 (
    .s_clk(s_clk), .rst(rst), .tx_data(dat[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0])
  );
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0)) u_8e1 (
    .s_clk(s_clk), .rst(rst), .tx_data(dat[1][7:0]), .tx_valid(vld[1]),
    .tx_ready(rdy_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1])
  );
  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .MSB_FIRST(0)) u_7o2 (
    .s_clk(s_clk), .rst(rst), .tx_data(dat[2][6:0]), .tx_valid(vld[2]),
    .tx_ready(rdy_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2])
  );
  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(1)) u_8n1_msb (
    .s_clk(s_clk), .rst(rst), .tx_data(dat[3][7:0]), .tx_valid(vld[3]),
    .tx_ready(rdy_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3])
  );

  initial begin
    s_clk = 1'b0;
    forever #5 s_clk = ~s_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int flen(input int k);
    return 1 + db_a[k] + ((par_a[k] != 0) ? 1 : 0) + sb_a[k];
  endfunction

  // Appends the expected line bits of one frame, and a flag marking its final stop bit.
  task automatic model_push(input int k, input logic [8:0] d);
    int ones = 0;
    exp_q.push_back(1'b0);
    last_q.push_back(1'b0);
    for (int i = 0; i < db_a[k]; i++) begin
      int b = (msb_a[k] != 0) ? (db_a[k] - 1 - i) : i;
      bit v = ((d >> b) & 9'd1) != 0;
      ones += int'(v);
      exp_q.push_back(v);
      last_q.push_back(1'b0);
    end
    if (par_a[k] != 0) begin
      exp_q.push_back((par_a[k] == 2) ? bit'(ones % 2) : bit'(1 - ones % 2));
      last_q.push_back(1'b0);
    end
    for (int s = 0; s < sb_a[k]; s++) begin
      exp_q.push_back(1'b1);
      last_q.push_back(s == sb_a[k] - 1);
    end
  endtask

  // Sends words_q on instance k with tx_valid held between words, checking every cycle.
  task automatic send_words(input int k, input string tag);
    int  n = words_q.size();
    int  a = 0;
    int  prev_done = -1;
    int  total;
    bit  last_prev = 1'b1;
    exp_q.delete();
    last_q.delete();
    foreach (words_q[i]) model_push(k, words_q[i]);
    total = exp_q.size();
    @(negedge s_clk);
    chk($sformatf("%s ready_before", tag), 32'(rdy_w[k]), 32'd1);
    vld[k] = 1'b1;
    dat[k] = words_q[0];
    for (int c = 0; c < total; c++) begin
      @(negedge s_clk);
      if (last_prev) begin
        a++;
        if (a < n) begin
          dat[k] = words_q[a];
        end else begin
          vld[k] = 1'b0;
          dat[k] = 9'($urandom);
        end
      end
      chk($sformatf("%s tx[%0d]", tag, c), 32'(tx_w[k]), 32'(exp_q[c]));
      chk($sformatf("%s done[%0d]", tag, c), 32'(done_w[k]), 32'(last_q[c]));
      chk($sformatf("%s ready[%0d]", tag, c), 32'(rdy_w[k]), 32'(last_q[c]));
      chk($sformatf("%s busy[%0d]", tag, c), 32'(busy_w[k]), 32'd1);
      if (last_q[c]) begin
        if (prev_done >= 0) chk($sformatf("%s done_gap", tag), 32'(c - prev_done), 32'(flen(k)));
        prev_done = c;
      end
      last_prev = last_q[c];
    end
    @(negedge s_clk);
    chk($sformatf("%s idle_tx", tag), 32'(tx_w[k]), 32'd1);
    chk($sformatf("%s idle_busy", tag), 32'(busy_w[k]), 32'd0);
    chk($sformatf("%s idle_ready", tag), 32'(rdy_w[k]), 32'd1);
    chk($sformatf("%s idle_done", tag), 32'(done_w[k]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset tx%0d", k), 32'(tx_w[k]), 32'd1);
      chk($sformatf("reset ready%0d", k), 32'(rdy_w[k]), 32'd1);
      chk($sformatf("reset busy%0d", k), 32'(busy_w[k]), 32'd0);
      chk($sformatf("reset done%0d", k), 32'(done_w[k]), 32'd0);
    end
    @(negedge s_clk);
    rst = 1'b0;

    words_q = '{9'h0A5};
    send_words(0, "8n1_a5");
    words_q = '{9'h007};
    send_words(1, "8e1_07");
    words_q = '{9'h000};
    send_words(2, "7o2_00");
    words_q = '{9'h080};
    send_words(3, "msb_80");
    words_q = '{9'h055, 9'h0AA};
    send_words(0, "b2b_55_aa");

    // Abort a frame with reset during data bit 3 of 0x00.
    @(negedge s_clk);
    vld[0] = 1'b1;
    dat[0] = 9'h000;
    for (int c = 0; c < 5; c++) begin
      @(negedge s_clk);
      vld[0] = 1'b0;
      chk($sformatf("abort tx[%0d]", c), 32'(tx_w[0]), 32'd0);
      chk($sformatf("abort done[%0d]", c), 32'(done_w[0]), 32'd0);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort async_tx", 32'(tx_w[0]), 32'd1);
    chk("abort async_busy", 32'(busy_w[0]), 32'd0);
    chk("abort async_done", 32'(done_w[0]), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge s_clk);
      chk("abort held_tx", 32'(tx_w[0]), 32'd1);
      chk("abort held_done", 32'(done_w[0]), 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge s_clk);
      chk("abort post_ready", 32'(rdy_w[0]), 32'd1);
      chk("abort post_tx", 32'(tx_w[0]), 32'd1);
      chk("abort post_done", 32'(done_w[0]), 32'd0);
    end
    words_q = '{9'h03C};
    send_words(0, "post_reset_3c");

    // Random words, single and chained, with random idle gaps.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 4; r++) begin
        int gap = int'($urandom_range(0, 3));
        int cnt = int'($urandom_range(1, 3));
        logic [8:0] mask = 9'((1 << db_a[k]) - 1);
        for (int g = 0; g < gap; g++) begin
          @(negedge s_clk);
          chk($sformatf("rnd%0d gap_tx", k), 32'(tx_w[k]), 32'd1);
          chk($sformatf("rnd%0d gap_busy", k), 32'(busy_w[k]), 32'd0);
        end
        words_q.delete();
        for (int w = 0; w < cnt; w++) words_q.push_back(9'($urandom) & mask);
        send_words(k, $sformatf("rnd%0d_%0d", k, r));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
